// File: rtl/pkt_arbiter.sv
// pkt_arbiter: round-robin merge of NUM_PORTS packet streams onto one output.
// Packets with even parity (XOR of all bits == 0) are accepted and dropped.
// Ports:
//   clk, resetn            - clock, asynchronous active-low reset
//   pkt_data_in/pkt_vld_in - per-port packet and valid
//   pkt_rdy_out            - per-port ready (combinational grant, one-hot or zero)
//   pkt_data_out/vld_out   - registered merged output packet and valid
//   pkt_rdy_in             - downstream ready
//   cnt_clr_in             - synchronous clear of all counters
//   fwd_cnt_out            - per-port forwarded-packet counters
//   err_cnt_out            - dropped (bad parity) packet counter
module pkt_arbiter #(
    parameter int unsigned PACKET_BITS = 72,
    parameter int unsigned NUM_PORTS   = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [PACKET_BITS-1:0] pkt_data_in [NUM_PORTS],
    input  logic [NUM_PORTS-1:0]   pkt_vld_in,
    output logic [NUM_PORTS-1:0]   pkt_rdy_out,
    output logic [PACKET_BITS-1:0] pkt_data_out,
    output logic                   pkt_vld_out,
    input  logic                   pkt_rdy_in,
    input  logic                   cnt_clr_in,
    output logic [31:0]            fwd_cnt_out [NUM_PORTS],
    output logic [31:0]            err_cnt_out
);

    localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned CNT_W = 32;
    localparam logic [PTR_W-1:0] PTR_RESET = PTR_W'(NUM_PORTS - 1);

    logic [PTR_W-1:0]                  r_ptr;
    logic                              r_vld_out;
    logic [PACKET_BITS-1:0]            r_data_out;
    logic [NUM_PORTS-1:0][CNT_W-1:0]   r_fwd_cnt;
    logic [CNT_W-1:0]                  r_err_cnt;

    logic                   w_out_busy;
    logic                   w_found;
    logic [PTR_W-1:0]       w_grant_idx;
    logic [PTR_W-1:0]       w_cand;
    logic                   w_accept;
    logic [PACKET_BITS-1:0] w_sel_data;
    logic                   w_good;
    logic                   w_fwd_en;
    logic                   w_err_en;

    // Output slot cannot take a new packet while it holds one nobody consumes.
    assign w_out_busy = r_vld_out & ~pkt_rdy_in;

    // Rotating priority search: ptr+1 first, ptr itself last.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            w_cand = PTR_W'((32'(r_ptr) + k) % NUM_PORTS);
            if (!w_found && pkt_vld_in[w_cand]) begin
                w_found     = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    // Grant gated by resetn so no ready is shown while reset is held.
    assign w_accept    = resetn & w_found & ~w_out_busy;
    assign pkt_rdy_out = w_accept ? (NUM_PORTS'(1) << w_grant_idx) : '0;

    assign w_sel_data = pkt_data_in[w_grant_idx];
    assign w_good     = ^w_sel_data;
    assign w_fwd_en   = w_accept & w_good;
    assign w_err_en   = w_accept & ~w_good;

    // Pointer and output register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ptr      <= PTR_RESET;
            r_vld_out  <= 1'b0;
            r_data_out <= '0;
        end else begin
            if (w_accept) begin
                r_ptr <= w_grant_idx;
            end
            if (!w_out_busy) begin
                r_vld_out <= w_fwd_en;
            end
            if (w_fwd_en) begin
                r_data_out <= w_sel_data;
            end
        end
    end

    // Statistics counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fwd_cnt <= '0;
            r_err_cnt <= '0;
        end else if (cnt_clr_in) begin
            r_fwd_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_fwd_en) begin
                r_fwd_cnt[w_grant_idx] <= r_fwd_cnt[w_grant_idx] + CNT_W'(1);
            end
            if (w_err_en) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign pkt_data_out = r_data_out;
    assign pkt_vld_out  = r_vld_out;
    assign err_cnt_out  = r_err_cnt;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_fwd
        assign fwd_cnt_out[g] = r_fwd_cnt[g];
    end

endmodule
